timer_arbiter: RTL and testbench
================================

# timer_arbiter

Shared interval-timer scheduler. Up to N requesters compete for one programmable counter. The block grants the counter to one requester at a time in round-robin order, loads that requester's interval, and counts it out. When the interval expires it returns a one-cycle `done` pulse to the owner. It sits between the lab's control FSMs and a single counter resource, replacing per-client free-running pulse counters.

## Interface

Parameters:
- `N`, 4 – number of requesters, 2..8.
- `W`, 8 – interval/counter width in bits.

Ports:
- `clk`  in  1 – single clock, all state on posedge.
- `rst`  in  1 – asynchronous, active-low reset.
- `en`  in  1 – global count enable; 0 freezes the counter, state and outputs hold.
- `req`  in  N – per-requester request level.
- `len`  in  N*W – interval per requester; slice i is `len[i*W +: W]`.
- `grant`  out  N – one-hot owner of the counter, 0 when idle.
- `done`  out  N – one-cycle pulse to the owner when its interval expires.
- `busy`  out  1 – 1 in COUNT or DONE.
- `count`  out  W – current counter value, for debug.

## Operation

- FSM states: IDLE, COUNT, DONE.
- **IDLE**
  - If any `req` is set, pick winner w: the first set bit at or after priority pointer `ptr`, wrapping modulo N.
  - Next edge: state=COUNT, `grant`=onehot(w), `count`=0, latch `max_q`=`len[w]`.
  - `len` is sampled only at this point; later changes are ignored.
- **COUNT**
  - If `req[w]`=0, cancel: next state IDLE, `grant`=0, no `done`, `ptr`=w+1 mod N.
  - Else if `en`=0, hold.
  - Else if `count`==`max_q`, next state DONE.
  - Else `count`=`count`+1.
- **DONE**
  - `done[w]`=1 and `grant` still held for exactly one cycle; `en` is ignored.
  - Next edge: state IDLE, `grant`=0, `count`=0, `ptr`=w+1 mod N.
- Handshake: a requester holds `req` until it sees `done` (or wants to cancel). It must drop `req` by the cycle after `done`, or it is re-arbitrated as a new request.
- Width rules:
  - `count` is W bits and never wraps, because `max_q`≤2^W−1 and the compare stops it.
  - `ptr` is clog2(N) bits, with explicit wrap at N−1 for non-power-of-two N.
- Simultaneous events:
  - New requests during COUNT/DONE are not served until IDLE.
  - Cancel has priority over `en`=0 and over expiry in the same cycle.

## Timing

- Reset values: state=IDLE, `grant`=0, `done`=0, `busy`=0, `count`=0, `ptr`=0, `max_q`=0.
- Reset applies immediately and asynchronously, including mid-COUNT; no `done` is issued for the aborted job.
- With `en`=1 throughout and `req` first seen in IDLE at cycle 0:
  - `grant` is visible at cycle 1.
  - COUNT lasts `len`+1 cycles.
  - `done` is high at cycle `len`+2.
  - IDLE at cycle `len`+3, and the earliest next grant is at cycle `len`+4.
- `len`=0 gives `done` at cycle 2.
- Each `en`=0 cycle during COUNT adds one cycle of latency.
- All outputs are registered, or decoded from registered state only; there is no combinational path from `req`/`len` to outputs.

## Structure

- Package `timer_arbiter_pkg`: `state_t` enum {IDLE, COUNT, DONE}, and a helper function for ptr width.
- Sub-module `rr_pick`: combinational round-robin priority pick.
  - Inputs: `req`[N], `ptr`.
  - Outputs: `valid`, `idx`, `onehot`.
  - Reusable by other arbiters in the lab.
- Top level holds the FSM, `count`/`max_q`/`ptr` registers and output decode.

## Test plan

- **Single request:** `req`[1]=1, `len`[1]=3 → `grant`=0010 at cycle 1, `count` 0..3, `done`=0010 only at cycle 5, IDLE at cycle 6.
- **Contention:** `req`=0101, `len`[0]=2, `len`[2]=5, both held → requester 0 served first (`done` at cycle 4), requester 2 granted at cycle 6, `done` at cycle 12.
- **Fairness:** all four held, `len`=0 each, each requester drops `req` for one cycle after its `done` → grant order 0,1,2,3,0,1…, no requester granted twice before the others.
- **len=0 and max:**
  - `len`=0 → `done` at cycle 2.
  - `len`=255 (W=8) → `count` reaches 255 without wrap, `done` at cycle 257.
- **en gating and cancel:**
  - `len`=4 with `en` low for 3 cycles mid-COUNT → `done` moves from cycle 6 to cycle 9.
  - Drop `req` at count=2 → `grant`=0 next cycle, no `done`, and `ptr` advances.
- **Async reset mid-operation:** assert `rst`=0 between clock edges at count=3 → all outputs zero immediately. Release `rst` and re-request → requester 0 wins ties (`ptr`=0).

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// rtl/timer_arbiter_pkg.sv - shared types and helpers for the interval-timer arbiter
package timer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pointer/index width; a single requester still needs one bit to hold index 0.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// rtl/timer_arbiter_rr_pick.sv - combinational round-robin pick: first request at or after ptr
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx,
    output logic [N-1:0]  onehot
);

    localparam logic [PW:0] N_W = (PW+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    // Rotate requests so that bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        valid = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                valid = 1'b1;
                off   = PW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        idx    = sum[PW-1:0];
        onehot = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - round-robin scheduler sharing one interval counter among N requesters
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] len,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy,
    output logic [W-1:0]   count
);

    localparam int PW = ptr_width(N);

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  max_q,   max_d;

    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] ptr_after_owner;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Explicit wrap so non-power-of-two N never lands on an unused index.
    assign ptr_after_owner = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        max_d   = max_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = COUNT;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    count_d = '0;
                    max_d   = len[int'(pick_idx)*W +: W];
                end
            end
            COUNT: begin
                // Owner dropping its request outranks both the enable and expiry.
                if ((req & grant_q) == '0) begin
                    state_d = IDLE;
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = ptr_after_owner;
                end else if (en) begin
                    if (count_q == max_q) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
                ptr_d   = ptr_after_owner;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            max_q   <= max_d;
        end
    end

    assign grant = grant_q;
    assign done  = (state_q == DONE) ? grant_q : '0;
    assign busy  = (state_q != IDLE);
    assign count = count_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// tb/tb_timer_arbiter.sv - randomized and directed self-checking bench for timer_arbiter
module tb_timer_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int VW = 2 * N + W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] len = '0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_phase;
    int m_owner;
    int m_k;
    int m_max;
    int m_ptr;

    timer_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .req   (req),
        .len   (len),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        en  = 1'b1;
        len = '0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {grant, done, busy, count};
    endfunction

    // Expected outputs at cycle c for one job granted at cycle g with interval l to requester i.
    function automatic logic [VW-1:0] job_vec(int c, int g, int l, int i);
        logic [N-1:0] oh;
        oh = N'(1) << i;
        if (c < g || c > g + l + 1) return '0;
        if (c <= g + l) return {oh, {N{1'b0}}, 1'b1, W'(c - g)};
        return {oh, oh, 1'b1, W'(l)};
    endfunction

    task automatic model_edge();
        if (m_phase == 0) begin
            for (int j = 0; j < N; j++) begin
                if (m_phase == 0 && req[(m_ptr + j) % N]) begin
                    m_owner = (m_ptr + j) % N;
                    m_max   = int'(len[m_owner*W +: W]);
                    m_k     = 0;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (!req[m_owner]) begin
                m_phase = 0;
                m_ptr   = (m_owner + 1) % N;
            end else if (en) begin
                if (m_k == m_max) m_phase = 2;
                else m_k = m_k + 1;
            end
        end else begin
            m_phase = 0;
            m_ptr   = (m_owner + 1) % N;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL reset_hold: got %h want 0", obs_vec());
        end
        rst = 1'b1;
        tick();
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL reset_release: got %h want 0", obs_vec());
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] exp;
        do_reset();
        len[1*W +: W] = 8'd3;
        req = 4'b0010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp = job_vec(c, 1, 3, 1);
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL single c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 5) req = '0;
        end
    endtask

    task automatic test_contention();
        logic [VW-1:0] exp;
        do_reset();
        len[0*W +: W] = 8'd2;
        len[2*W +: W] = 8'd5;
        req = 4'b0101;
        for (int c = 1; c <= 13; c++) begin
            tick();
            exp = job_vec(c, 1, 2, 0) | job_vec(c, 6, 5, 2);
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL contention c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 4)  req[0] = 1'b0;
            if (c == 12) req[2] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] prev_g;
        logic [N-1:0] restore;
        int ngrants;
        do_reset();
        req     = '1;
        prev_g  = '0;
        restore = '0;
        ngrants = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (grant != '0 && prev_g == '0) begin
                total++;
                if (grant !== (N'(1) << (ngrants % N))) begin
                    bad++;
                    $display("FAIL fairness_order n=%0d: got %b want %b", ngrants, grant, N'(1) << (ngrants % N));
                end
                ngrants++;
            end
            prev_g  = grant;
            req     = req | restore;
            restore = done;
            req     = req & ~done;
        end
        total++;
        if (ngrants != 8) begin
            bad++;
            $display("FAIL fairness_count: got %0d want 8", ngrants);
        end
    endtask

    task automatic test_len_edges();
        logic [VW-1:0] exp;
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 3; c++) begin
            tick();
            exp = job_vec(c, 1, 0, 0);
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL len_zero c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 2) req = '0;
        end
        do_reset();
        len[3*W +: W] = 8'd255;
        req = 4'b1000;
        for (int c = 1; c <= 258; c++) begin
            tick();
            exp = job_vec(c, 1, 255, 3);
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL len_max c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 257) req = '0;
        end
    endtask

    task automatic test_en_gating();
        logic [VW-1:0] exp;
        int k;
        do_reset();
        len[0*W +: W] = 8'd4;
        req = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            tick();
            k = (c <= 2) ? c - 1 : (c <= 5) ? 1 : c - 4;
            if (c <= 8)       exp = {4'b0001, 4'b0000, 1'b1, W'(k)};
            else if (c == 9)  exp = {4'b0001, 4'b0001, 1'b1, W'(4)};
            else              exp = '0;
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL en_gating c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 2) en = 1'b0;
            if (c == 5) en = 1'b1;
            if (c == 9) req = '0;
        end
    endtask

    task automatic test_cancel();
        logic [VW-1:0] exp;
        do_reset();
        len[1*W +: W] = 8'd10;
        len[2*W +: W] = 8'd3;
        req = 4'b0010;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c <= 3)      exp = job_vec(c, 1, 10, 1);
            else if (c <= 6) exp = '0;
            else             exp = job_vec(c, 7, 3, 2);
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL cancel c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            if (c == 3) req = '0;
            if (c == 6) req = 4'b0110;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        req = '0;
        tick();
        len[3*W +: W] = 8'd6;
        req = 4'b1000;
        for (int c = 1; c <= 4; c++) tick();
        total++;
        if (count !== 8'd3) begin
            bad++;
            $display("FAIL async_pre count: got %0d want 3", count);
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL async_immediate: got %h want 0", obs_vec());
        end
        tick();
        total++;
        if (obs_vec() !== '0) begin
            bad++;
            $display("FAIL async_held: got %h want 0", obs_vec());
        end
        len[0*W +: W] = 8'd2;
        len[2*W +: W] = 8'd2;
        req = 4'b0101;
        rst = 1'b1;
        tick();
        total++;
        if (obs_vec() !== job_vec(1, 1, 2, 0)) begin
            bad++;
            $display("FAIL async_rearb: got %h want %h", obs_vec(), job_vec(1, 1, 2, 0));
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] exp;
        logic [N-1:0]  oh;
        int cool [N];
        do_reset();
        m_phase = 0;
        m_owner = 0;
        m_k     = 0;
        m_max   = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) cool[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            model_edge();
            tick();
            oh = N'(1) << m_owner;
            if (m_phase == 0)      exp = '0;
            else if (m_phase == 1) exp = {oh, {N{1'b0}}, 1'b1, W'(m_k)};
            else                   exp = {oh, oh, 1'b1, W'(m_max)};
            total++;
            if (obs_vec() !== exp) begin
                bad++;
                $display("FAIL random c=%0d: got %h want %h", c, obs_vec(), exp);
            end
            for (int i = 0; i < N; i++) begin
                if (m_phase == 2 && m_owner == i) begin
                    req[i]  = 1'b0;
                    cool[i] = int'($urandom_range(1, 2));
                end else if (req[i] && m_phase == 1 && m_owner == i && ($urandom % 32) == 0) begin
                    req[i]  = 1'b0;
                    cool[i] = 1;
                end else if (!req[i]) begin
                    if (cool[i] > 0) cool[i]--;
                    else if (($urandom % 3) == 0) begin
                        req[i]        = 1'b1;
                        len[i*W +: W] = W'($urandom_range(0, 12));
                    end
                end else if (($urandom % 8) == 0) begin
                    len[i*W +: W] = W'($urandom_range(0, 12));
                end
            end
            en = (m_phase == 1) ? (($urandom % 4) != 0) : 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_len_edges();
        test_en_gating();
        test_cancel();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
